// File: rtl/sum_series_pkg.sv
// Shared encodings for the sum-series engines (state codes and mode select).
// Latency: n/a (constants only).
// Backpressure: n/a.
// Also used by the control path of the legacy fixed-width sum-to-N block, so
// these encodings must not be renumbered.
package sum_series_pkg;

   // Control FSM state codes
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] BUSY = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   // Term selection: linear series or series of squares
   localparam logic MODE_LIN = 1'b0;
   localparam logic MODE_SQR = 1'b1;

endpackage

// File: rtl/sum_series_term.sv
// Term generator for the series accumulator: i or i*i, zero-extended.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
// Ports:
//   i    in  N_W    current index
//   mode in  1      MODE_LIN -> i, MODE_SQR -> i*i
//   term out 2*N_W  selected term; i*i always fits in 2*N_W bits
module sum_series_term
   import sum_series_pkg::*;
#(
   parameter int N_W = 4
) (
   input  logic [N_W-1:0]   i,
   input  logic             mode,
   output logic [2*N_W-1:0] term
);

   logic [2*N_W-1:0] i_ext;

   assign i_ext = {{N_W{1'b0}}, i};

   always_comb begin
      term = i_ext;
      if (mode == MODE_SQR) begin
         term = i_ext * i_ext;
      end
   end

endmodule

// File: rtl/sum_series_acc.sv
// Sum-series engine: sum of i or i^2 for i = 1..n, one term per clock, saturating.
// Latency: n cycles from acceptance to out_valid (1 cycle when n==0).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ack.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   in_valid/in_ready     request handshake; n and mode captured on accept
//   abort                 cancels a computation in BUSY, partial sum kept
//   out_valid/out_ack     result handshake; sum/overflow frozen while valid
//   sum, overflow         saturating result and sticky saturation flag
module sum_series_acc
   import sum_series_pkg::*;
#(
   parameter int N_W   = 4,
   parameter int SUM_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_W-1:0]   n,
   input  logic             mode,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ack,
   output logic [SUM_W-1:0] sum,
   output logic             overflow
);

   if (SUM_W < 2*N_W) begin : g_bad_width
      $error("sum_series_acc: SUM_W must be at least 2*N_W");
   end

   logic [1:0]       state_q, state_d;
   logic [N_W-1:0]   i_q,     i_d;
   logic             mode_q,  mode_d;
   logic [SUM_W-1:0] sum_q,   sum_d;
   logic             ovf_q,   ovf_d;

   logic [2*N_W-1:0] term;
   logic [SUM_W:0]   add;

   sum_series_term #(
      .N_W (N_W)
   ) u_term (
      .i    (i_q),
      .mode (mode_q),
      .term (term)
   );

   // One extra bit so the carry-out flags saturation directly
   always_comb begin
      add = {1'b0, sum_q} + {1'b0, SUM_W'(term)};
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      mode_d  = mode_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               i_d     = n;
               mode_d  = mode;
               sum_d   = '0;
               ovf_d   = 1'b0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (abort) begin
               state_d = IDLE;
            end else if (i_q == '0) begin
               // Zero-length request: one pass with nothing to add, which
               // keeps its result latency at one cycle.
               state_d = DONE;
            end else begin
               // Once saturated, sum is all-ones and any further term
               // (always >= 1 here) carries out again, so it stays pinned.
               if (add[SUM_W]) begin
                  sum_d = '1;
                  ovf_d = 1'b1;
               end else begin
                  sum_d = add[SUM_W-1:0];
               end
               i_d = i_q - N_W'(1);
               if (i_q == N_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (out_ack) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         i_q     <= '0;
         mode_q  <= MODE_LIN;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         mode_q  <= mode_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign overflow  = ovf_q;

endmodule
